reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- Parametrised successor to the single-bit load register: a bank of DEPTH words, each WIDTH bits wide, with one write port and two read ports.
- Each word behaves as a load register, extended with an increment operation (program-counter semantics) and a registered wrap flag.
- Sits in the memory/register layer beneath the CPU; used as RAMn / register-file building block and as a multi-context PC store.

Parameters:
- WIDTH, 16, bits per word (>=1).
- DEPTH, 8, number of words (>=2; need not be a power of 2).
- BYPASS, 0, 1 = read ports show the value being written this cycle (write-through); 0 = read ports show stored contents only.
- AW, $clog2(DEPTH), address width (derived localparam, not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- in  input  WIDTH  write data.
- load  input  1  write `in` to word[waddr] at next posedge.
- inc  input  1  word[waddr] <= word[waddr] + 1 at next posedge.
- waddr  input  AW  target word for load/inc.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- out_a  output  WIDTH  combinational read of word[raddr_a].
- out_b  output  WIDTH  combinational read of word[raddr_b].
- wrap  output  1  registered; high for exactly one cycle after an inc that wrapped all-ones to zero.

Behaviour:
- Operation priority at each posedge, per target word: reset > load > inc > hold.
- reset=1:
  - All DEPTH words <= 0 and wrap <= 0.
  - load/inc in the same cycle are ignored.
  - Reset mid-sequence discards any pending operation; no partial update.
- Before the first reset, contents are undefined (X in simulation). The bench must reset first.
- load=1 (reset=0): word[waddr] <= in. inc is ignored even if also asserted. wrap <= 0.
- inc=1, load=0 (reset=0):
  - word[waddr] <= (word[waddr] + 1) mod 2^WIDTH.
  - wrap <= 1 iff the old value was all ones; otherwise wrap <= 0.
- No operation: all words hold; wrap <= 0. wrap therefore never stays high for two consecutive cycles unless consecutive wrapping incs occur.
- Only word[waddr] changes in any cycle; all other words hold.
- Out-of-range addresses (waddr >= DEPTH, only possible when DEPTH is not a power of 2):
  - load/inc are ignored and wrap <= 0.
  - Reads at raddr >= DEPTH return 0.
- Reads:
  - Combinational, zero latency. A write is visible on out_a/out_b after the posedge that commits it.
  - Both ports may address the same word, and may address the word being written.
- BYPASS=1: when reset=0, a write is active (load or inc, in-range), and raddr_x == waddr, out_x shows the next value (in, or old+1 wrapped) combinationally in the same cycle. With reset=1, outputs show stored contents (no bypass of zeroes).
- BYPASS=0: outputs never depend on in/load/inc in the same cycle.
- Storage: flip-flops only, no memory macro inference requirement. Semantics per word are identical to the load register: load=0 holds, load=1 captures on posedge.

Test Plan:
- Reset then read all: reset=1 for 1 cycle, sweep raddr_a/raddr_b over 0..7 -> all outputs 0x0000, wrap=0.
- Load and hold: load=1, waddr=3, in=0x1234 for 1 cycle; then load=0, in=0xFFFF for 3 cycles -> out_a (raddr_a=3) = 0x1234 throughout; word 2 and word 4 remain 0x0000.
- Priority: reset=1, load=1, inc=1, waddr=5, in=0x00AA -> word5=0x0000 after posedge. Next cycle load=1, inc=1, in=0x00AA -> word5=0x00AA, not 0x00AB.
- Increment wrap: load 0xFFFE into word 7; inc for 2 cycles -> word7 = 0xFFFF (wrap=0), then 0x0000 with wrap=1 for exactly one cycle. A third inc -> 0x0001, wrap=0.
- Bypass: BYPASS=1, word 1 = 0x0010, load=1, waddr=1, in=0x0020, raddr_a=1 -> out_a=0x0020 before the posedge. With BYPASS=0 the same stimulus -> out_a=0x0010 until the posedge, then 0x0020.
- Non-power-of-2 depth: DEPTH=5, AW=3. load=1, waddr=6, in=0x5555 -> no word changes; raddr_b=6 -> out_b=0x0000; words 0..4 unchanged.

Source files
------------

// File: rtl/reg_bank_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : reg_bank_if                                        |
// | Description : Write/read bus bundle for the reg_bank register    |
// |               file (one write port, two read ports, wrap flag).  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface reg_bank_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) ();
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             wrap;

  modport master (
    output in, load, inc, waddr, raddr_a, raddr_b,
    input  out_a, out_b, wrap
  );

  modport slave (
    input  in, load, inc, waddr, raddr_a, raddr_b,
    output out_a, out_b, wrap
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : reg_bank                                           |
// | Description : DEPTH x WIDTH flip-flop register bank with load,   |
// |               increment (PC style) and a registered wrap flag.   |
// |               One write port, two combinational read ports,      |
// |               optional write-through bypass.                     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module reg_bank #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 0
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] words [DEPTH];
  logic             wrap_q;
  logic             addr_ok;
  logic             wr_en;
  logic             wrap_next;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // Write port: fetch the target word and compute what it becomes (load beats inc)
  always_comb begin
    addr_ok = ({1'b0, bus.waddr} < C_DEPTH);
    cur_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.waddr == AW'(i)) cur_val = words[i];
    end
    wr_en     = addr_ok && (bus.load || bus.inc);
    next_val  = bus.load ? bus.in : cur_val + WIDTH'(1);
    wrap_next = addr_ok && bus.inc && !bus.load && (cur_val == {WIDTH{1'b1}});
  end

  // Storage and wrap flag: reset clears everything, otherwise only word[waddr] may change
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (bus.waddr == AW'(i))) words[i] <= next_val;
      end
      wrap_q <= wrap_next;
    end
  end

  // Read muxes over stored contents; out-of-range addresses fall through to zero
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == AW'(i)) stored_a = words[i];
      if (bus.raddr_b == AW'(i)) stored_b = words[i];
    end
  end

  if (BYPASS != 0) begin : g_bypass
    // Write-through: a port reading the word being written sees its next value now
    logic fwd_a;
    logic fwd_b;
    assign fwd_a     = !reset && wr_en && (bus.raddr_a == bus.waddr);
    assign fwd_b     = !reset && wr_en && (bus.raddr_b == bus.waddr);
    assign bus.out_a = fwd_a ? next_val : stored_a;
    assign bus.out_b = fwd_b ? next_val : stored_b;
  end else begin : g_direct
    assign bus.out_a = stored_a;
    assign bus.out_b = stored_b;
  end

  assign bus.wrap = wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_reg_bank                                        |
// | Description : Directed self-checking bench for reg_bank. Three   |
// |               instances: 8 words no bypass, 8 words bypass,      |
// |               5 words (non power of two) no bypass.              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_reg_bank;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_bank_if #(.WIDTH(16), .AW(3)) bus0 ();
  reg_bank_if #(.WIDTH(16), .AW(3)) bus1 ();
  reg_bank_if #(.WIDTH(16), .AW(3)) bus5 ();

  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  reg_bank #(.WIDTH(16), .DEPTH(5), .BYPASS(0)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.in = '0; bus0.load = 0; bus0.inc = 0; bus0.waddr = '0; bus0.raddr_a = '0; bus0.raddr_b = '0;
    bus1.in = '0; bus1.load = 0; bus1.inc = 0; bus1.waddr = '0; bus1.raddr_a = '0; bus1.raddr_b = '0;
    bus5.in = '0; bus5.load = 0; bus5.inc = 0; bus5.waddr = '0; bus5.raddr_a = '0; bus5.raddr_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus0.raddr_a = 3'(i);
      bus0.raddr_b = 3'(7 - i);
      bus5.raddr_a = 3'(i);
      #1;
      checks++;
      if (bus0.out_a !== 16'h0000 || bus0.out_b !== 16'h0000) begin
        failures++;
        $display("FAIL reset_read addr=%0d got a=%h b=%h exp 0000", i, bus0.out_a, bus0.out_b);
      end
      checks++;
      if (bus5.out_a !== 16'h0000) begin
        failures++;
        $display("FAIL reset_read5 addr=%0d got %h exp 0000", i, bus5.out_a);
      end
    end
    checks++;
    if (bus0.wrap !== 1'b0 || bus1.wrap !== 1'b0 || bus5.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap got %b%b%b exp 000", bus0.wrap, bus1.wrap, bus5.wrap);
    end
  endtask

  task automatic test_load_hold();
    bus0.load = 1; bus0.waddr = 3'd3; bus0.in = 16'h1234;
    bus0.raddr_a = 3'd3; bus0.raddr_b = 3'd2;
    tick();
    bus0.load = 0; bus0.in = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      bus0.raddr_b = (c == 1) ? 3'd4 : 3'd2;
      #1;
      checks++;
      if (bus0.out_a !== 16'h1234) begin
        failures++;
        $display("FAIL load_hold cyc=%0d out_a got %h exp 1234", c, bus0.out_a);
      end
      checks++;
      if (bus0.out_b !== 16'h0000) begin
        failures++;
        $display("FAIL load_hold_neighbour cyc=%0d out_b got %h exp 0000", c, bus0.out_b);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    bus0.load = 1; bus0.waddr = 3'd5; bus0.in = 16'h7777; bus0.raddr_a = 3'd5;
    tick();
    reset = 1; bus0.load = 1; bus0.inc = 1; bus0.in = 16'h00AA;
    tick();
    reset = 0;
    #1;
    checks++;
    if (bus0.out_a !== 16'h0000) begin
      failures++;
      $display("FAIL prio_reset word5 got %h exp 0000", bus0.out_a);
    end
    tick();
    checks++;
    if (bus0.out_a !== 16'h00AA || bus0.wrap !== 1'b0) begin
      failures++;
      $display("FAIL prio_load_over_inc word5 got %h wrap %b exp 00aa wrap 0", bus0.out_a, bus0.wrap);
    end
    bus0.load = 0; bus0.inc = 0;
  endtask

  task automatic test_inc_wrap();
    logic [15:0] exp_v [3];
    logic        exp_w [3];
    exp_v[0] = 16'hFFFF; exp_w[0] = 1'b0;
    exp_v[1] = 16'h0000; exp_w[1] = 1'b1;
    exp_v[2] = 16'h0001; exp_w[2] = 1'b0;
    bus0.load = 1; bus0.waddr = 3'd7; bus0.in = 16'hFFFE; bus0.raddr_a = 3'd7;
    tick();
    bus0.load = 0; bus0.inc = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus0.out_a !== exp_v[c] || bus0.wrap !== exp_w[c]) begin
        failures++;
        $display("FAIL inc_wrap step=%0d got %h wrap %b exp %h wrap %b",
                 c, bus0.out_a, bus0.wrap, exp_v[c], exp_w[c]);
      end
    end
    bus0.inc = 0;
    tick();
    checks++;
    if (bus0.out_a !== 16'h0001 || bus0.wrap !== 1'b0) begin
      failures++;
      $display("FAIL inc_idle got %h wrap %b exp 0001 wrap 0", bus0.out_a, bus0.wrap);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bus0.load = 1; bus0.waddr = 3'(i); bus0.in = 16'hA000 + 16'(i);
      tick();
    end
    bus0.load = 0; bus0.inc = 1; bus0.waddr = 3'd5;
    tick();
    tick();
    bus0.inc = 0;
    for (int i = 0; i < 8; i++) begin
      bus0.raddr_a = 3'(i);
      bus0.raddr_b = 3'(i);
      #1;
      checks++;
      if (bus0.out_a !== ((i == 5) ? 16'hA007 : 16'hA000 + 16'(i)) || bus0.out_b !== bus0.out_a) begin
        failures++;
        $display("FAIL back_to_back word=%0d got a=%h b=%h exp %h", i, bus0.out_a, bus0.out_b,
                 (i == 5) ? 16'hA007 : 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_bypass();
    bus0.load = 1; bus0.waddr = 3'd1; bus0.in = 16'h0010;
    bus1.load = 1; bus1.waddr = 3'd1; bus1.in = 16'h0010;
    tick();
    bus0.in = 16'h0020; bus0.raddr_a = 3'd1;
    bus1.in = 16'h0020; bus1.raddr_a = 3'd1; bus1.raddr_b = 3'd2;
    #1;
    checks++;
    if (bus1.out_a !== 16'h0020) begin
      failures++;
      $display("FAIL bypass_fwd got %h exp 0020", bus1.out_a);
    end
    checks++;
    if (bus0.out_a !== 16'h0010) begin
      failures++;
      $display("FAIL nobypass_pre got %h exp 0010", bus0.out_a);
    end
    checks++;
    if (bus1.out_b !== 16'h0000) begin
      failures++;
      $display("FAIL bypass_other_port got %h exp 0000", bus1.out_b);
    end
    tick();
    bus0.load = 0;
    bus1.load = 0; bus1.inc = 1; bus1.raddr_b = 3'd1;
    #1;
    checks++;
    if (bus0.out_a !== 16'h0020 || bus1.out_b !== 16'h0021) begin
      failures++;
      $display("FAIL bypass_post got a0=%h b1=%h exp 0020 0021", bus0.out_a, bus1.out_b);
    end
    tick();
    bus1.inc = 0;
    reset = 1; bus1.load = 1; bus1.in = 16'hBEEF;
    #1;
    checks++;
    if (bus1.out_a !== 16'h0021) begin
      failures++;
      $display("FAIL bypass_under_reset got %h exp 0021", bus1.out_a);
    end
    tick();
    reset = 0; bus1.load = 0;
    #1;
    checks++;
    if (bus1.out_a !== 16'h0000) begin
      failures++;
      $display("FAIL bypass_after_reset got %h exp 0000", bus1.out_a);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 5; i++) begin
      bus5.load = 1; bus5.waddr = 3'(i); bus5.in = 16'h1100 + 16'(i);
      tick();
    end
    bus5.load = 1; bus5.waddr = 3'd6; bus5.in = 16'h5555; bus5.raddr_b = 3'd6;
    #1;
    checks++;
    if (bus5.out_b !== 16'h0000) begin
      failures++;
      $display("FAIL oor_read_pre got %h exp 0000", bus5.out_b);
    end
    tick();
    bus5.load = 0; bus5.inc = 1; bus5.waddr = 3'd7;
    tick();
    bus5.inc = 0;
    checks++;
    if (bus5.out_b !== 16'h0000 || bus5.wrap !== 1'b0) begin
      failures++;
      $display("FAIL oor_read_post got %h wrap %b exp 0000 wrap 0", bus5.out_b, bus5.wrap);
    end
    for (int i = 0; i < 8; i++) begin
      bus5.raddr_a = 3'(i);
      #1;
      checks++;
      if (bus5.out_a !== ((i < 5) ? 16'h1100 + 16'(i) : 16'h0000)) begin
        failures++;
        $display("FAIL oor_words addr=%0d got %h exp %h", i, bus5.out_a,
                 (i < 5) ? 16'h1100 + 16'(i) : 16'h0000);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_load_hold();
    test_priority();
    test_inc_wrap();
    test_back_to_back();
    test_bypass();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
